// File: rtl/gam_param_fetch_if.sv
// Signal bundle between gam_param_fetch and its surroundings: upstream capture
// status, per-subset values, fetch request/response and the parameter BRAM port.
interface gam_param_fetch_if #(
  parameter int DATA_W = 32
) ();
  logic              subset_done;
  logic              parameters_done;
  logic [DATA_W-1:0] subset_counter;
  logic [DATA_W-1:0] num_of_subsets;
  logic [DATA_W-1:0] base_address;
  logic [DATA_W-1:0] num_pxl_Int_in;
  logic [DATA_W-1:0] num_pxl_FP_in;
  logic              gam_new_subset;
  logic [DATA_W-1:0] gam_subset_number;
  logic [DATA_W-1:0] param_dout;
  logic              param_ea;
  logic [3:0]        param_wea;
  logic [DATA_W-1:0] param_addr;
  logic [DATA_W-1:0] gam_cx;
  logic [DATA_W-1:0] gam_cy;
  logic [DATA_W-1:0] base_addr_out;
  logic [DATA_W-1:0] num_pxl_Int_out;
  logic [DATA_W-1:0] num_pxl_FP_out;
  logic              gam_interface_done;
  logic              busy;
`ifdef GAM_RANGE_CHECK_EN
  logic              subset_err;
`endif

  modport master (
    output subset_done, parameters_done, subset_counter, num_of_subsets,
           base_address, num_pxl_Int_in, num_pxl_FP_in, gam_new_subset,
           gam_subset_number, param_dout,
    input  param_ea, param_wea, param_addr, gam_cx, gam_cy, base_addr_out,
           num_pxl_Int_out, num_pxl_FP_out, gam_interface_done, busy
`ifdef GAM_RANGE_CHECK_EN
           , subset_err
`endif
  );

  modport slave (
    input  subset_done, parameters_done, subset_counter, num_of_subsets,
           base_address, num_pxl_Int_in, num_pxl_FP_in, gam_new_subset,
           gam_subset_number, param_dout,
    output param_ea, param_wea, param_addr, gam_cx, gam_cy, base_addr_out,
           num_pxl_Int_out, num_pxl_FP_out, gam_interface_done, busy
`ifdef GAM_RANGE_CHECK_EN
           , subset_err
`endif
  );
endinterface

// File: rtl/gam_param_fetch.sv
// Captures per-subset base/pixel tables, then on request fetches cx/cy for a subset
// from parameter BRAM. Optional GAM_RANGE_CHECK_EN adds subset_err and skips bad fetches.
module gam_param_fetch #(
  parameter int DATA_W            = 32,
  parameter int MAX_SUBSETS       = 14,
  parameter int PARAMS_PER_SUBSET = 5,
  parameter int CX_OFFSET         = 3,
  parameter int CY_OFFSET         = 4,
  parameter int RD_LAT            = 3,
  parameter int DONE_HOLD         = 3
) (
  input  logic              clock,
  input  logic              reset,
  gam_param_fetch_if.slave  bus
);
  localparam int IDX_W = (MAX_SUBSETS > 1) ? $clog2(MAX_SUBSETS) : 1;

  typedef enum logic [2:0] {
    CAPTURE, FLUSH, IDLE, CX_ADDR, CX_WAIT, CY_WAIT, DONE, HOLD
  } state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_idx;
  logic [DATA_W-1:0] r_base [MAX_SUBSETS];
  logic [DATA_W-1:0] r_int  [MAX_SUBSETS];
  logic [DATA_W-1:0] r_fp   [MAX_SUBSETS];
  logic [DATA_W-1:0] r_addr, r_cx, r_cy, r_base_out, r_int_out, r_fp_out;
  logic              r_done;

  logic              w_cap, w_base_wr, w_pix_wr, w_req, w_req_ok, w_err;
  logic              w_rd_last, w_hold_last;
  logic [DATA_W-1:0] w_sc_m1, w_cx_addr, w_cy_addr;
  logic [IDX_W-1:0]  w_sc_idx, w_pix_idx, w_req_idx;

  assign w_cap     = bus.parameters_done & ~bus.subset_done;
  assign w_sc_m1   = bus.subset_counter - DATA_W'(1);
  assign w_sc_idx  = bus.subset_counter[IDX_W-1:0];
  assign w_pix_idx = w_sc_m1[IDX_W-1:0];
  assign w_req_idx = bus.gam_subset_number[IDX_W-1:0];

  // Writes past the table depth are silently dropped.
  assign w_base_wr = (r_state == CAPTURE) && w_cap &&
                     (bus.subset_counter < bus.num_of_subsets) &&
                     (bus.subset_counter < DATA_W'(MAX_SUBSETS));
  assign w_pix_wr  = (((r_state == CAPTURE) && w_cap) || (r_state == FLUSH)) &&
                     (bus.subset_counter != '0) && (w_sc_m1 < DATA_W'(MAX_SUBSETS));

  assign w_req    = (r_state == IDLE) && bus.gam_new_subset && bus.parameters_done;
  assign w_req_ok = bus.gam_subset_number < DATA_W'(MAX_SUBSETS);
`ifdef GAM_RANGE_CHECK_EN
  assign w_err    = !w_req_ok || (bus.gam_subset_number >= bus.num_of_subsets);
`else
  assign w_err    = 1'b0;
`endif

  assign w_rd_last   = (r_cnt == 4'(RD_LAT - 1));
  assign w_hold_last = (r_cnt == 4'(DONE_HOLD - 1));

  // Byte addresses of the cx/cy words; record 0 is skipped, hence idx+1.
  assign w_cx_addr = ((r_idx + DATA_W'(1)) * DATA_W'(PARAMS_PER_SUBSET) + DATA_W'(CX_OFFSET)) << 2;
  assign w_cy_addr = ((r_idx + DATA_W'(1)) * DATA_W'(PARAMS_PER_SUBSET) + DATA_W'(CY_OFFSET)) << 2;

  always_comb begin
    w_next = r_state;
    case (r_state)
      CAPTURE: if (w_cap && (bus.subset_counter >= bus.num_of_subsets)) w_next = FLUSH;
      FLUSH:   w_next = IDLE;
      IDLE:    if (w_req) w_next = w_err ? DONE : CX_ADDR;
      CX_ADDR: w_next = CX_WAIT;
      CX_WAIT: if (w_rd_last) w_next = CY_WAIT;
      CY_WAIT: if (w_rd_last) w_next = DONE;
      DONE:    w_next = HOLD;
      HOLD:    if (w_hold_last) w_next = IDLE;
      default: w_next = CAPTURE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= CAPTURE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_base_out <= '0;
      r_int_out  <= '0;
      r_fp_out   <= '0;
      r_done     <= 1'b0;
      for (int i = 0; i < MAX_SUBSETS; i++) begin
        r_base[i] <= '0;
        r_int[i]  <= '0;
        r_fp[i]   <= '0;
      end
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state != w_next) ? 4'd0 : r_cnt + 4'd1;
      if (w_base_wr) r_base[w_sc_idx] <= bus.base_address;
      if (w_pix_wr) begin
        r_int[w_pix_idx] <= bus.num_pxl_Int_in;
        r_fp[w_pix_idx]  <= bus.num_pxl_FP_in;
      end
      if (w_req) begin
        r_idx <= bus.gam_subset_number;
        if (w_err) begin
          r_cx       <= '0;
          r_cy       <= '0;
          r_base_out <= '0;
          r_int_out  <= '0;
          r_fp_out   <= '0;
        end else begin
          r_base_out <= w_req_ok ? r_base[w_req_idx] : '0;
          r_int_out  <= w_req_ok ? r_int[w_req_idx]  : '0;
          r_fp_out   <= w_req_ok ? r_fp[w_req_idx]   : '0;
        end
      end
      case (r_state)
        CX_ADDR: r_addr <= w_cx_addr;
        CX_WAIT: if (w_rd_last) begin
          r_cx   <= bus.param_dout;
          r_addr <= w_cy_addr;
        end
        CY_WAIT: if (w_rd_last) r_cy <= bus.param_dout;
        DONE:    r_done <= 1'b1;
        HOLD:    if (w_hold_last) r_done <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef GAM_RANGE_CHECK_EN
  logic r_err;
  always_ff @(posedge clock) begin
    if (reset)      r_err <= 1'b0;
    else if (w_req) r_err <= w_err;
  end
  assign bus.subset_err = r_err;
`endif

  assign bus.param_ea           = (r_state != CAPTURE) && (r_state != FLUSH);
  assign bus.param_wea          = 4'b0000;
  assign bus.param_addr         = r_addr;
  assign bus.gam_cx             = r_cx;
  assign bus.gam_cy             = r_cy;
  assign bus.base_addr_out      = r_base_out;
  assign bus.num_pxl_Int_out    = r_int_out;
  assign bus.num_pxl_FP_out     = r_fp_out;
  assign bus.gam_interface_done = r_done;
  assign bus.busy               = (r_state != IDLE) && (r_state != CAPTURE);
endmodule
